// File: rtl/shift_register_32to128.sv
// ---------------------------------------------------------------------------
// shift_register_32to128
// Collects four 32-bit words into one 128-bit block with valid/ready
// handshakes on both sides. The block is presented on the same edge that
// accepts the fourth word. While the block is held, a new word is accepted
// only on an edge where the block is also consumed; that word starts the
// next block.
//
// Build option: define SR32TO128_LSB_FIRST_EN to place the first word at
// the LSB end of data_out. By default the first word lands in bits 127:96.
// ---------------------------------------------------------------------------
module shift_register_32to128 (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [31:0]  data_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   word_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_word_cnt;
    logic [2:0]     w_word_cnt_nxt;
    logic [127:0]   r_data;
    logic [127:0]   w_data_nxt;
    logic           w_in_fire;
    logic           w_out_fire;

    // Writes one word into its slot of the block; the build option only
    // changes which end of the block word 0 occupies.
    function automatic logic [127:0] placeWord(
        input logic [127:0] blk,
        input logic [1:0]   idx,
        input logic [31:0]  word
    );
        logic [127:0] res;
        logic [1:0]   slot;
        res = blk;
`ifdef SR32TO128_LSB_FIRST_EN
        slot = idx;
`else
        slot = 2'd3 - idx;
`endif
        res[{slot, 5'b00000} +: 32] = word;
        return res;
    endfunction

    // A held block only lets a new word in when it is being consumed on
    // the same edge, so the input side mirrors out_ready while FULL.
    assign in_ready   = (r_state == FILL) ? 1'b1 : out_ready;
    assign out_valid  = (r_state == FULL);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign data_out   = r_data;
    assign word_cnt   = r_word_cnt;

    // Next-state, next-count and next-block selection; clear overrides every transfer.
    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_data_nxt     = r_data;

        if (clear) begin
            w_state_nxt    = FILL;
            w_word_cnt_nxt = 3'd0;
            w_data_nxt     = 128'h0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_in_fire) begin
                        w_data_nxt = placeWord(r_data, r_word_cnt[1:0], data_in);
                        if (r_word_cnt >= 3'd3) begin
                            w_state_nxt    = FULL;
                            w_word_cnt_nxt = 3'd4;
                        end else begin
                            w_word_cnt_nxt = r_word_cnt + 3'd1;
                        end
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = FILL;
                        if (w_in_fire) begin
                            w_data_nxt     = placeWord(r_data, 2'd0, data_in);
                            w_word_cnt_nxt = 3'd1;
                        end else begin
                            w_word_cnt_nxt = 3'd0;
                        end
                    end
                end
                default: begin
                    w_state_nxt    = FILL;
                    w_word_cnt_nxt = 3'd0;
                end
            endcase
        end
    end

    // State, count and block registers; reset discards any partial block at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= FILL;
            r_word_cnt <= 3'd0;
            r_data     <= 128'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_data     <= w_data_nxt;
        end
    end

endmodule

// File: tb/tb_shift_register_32to128.sv
// ---------------------------------------------------------------------------
// tb_shift_register_32to128
// Directed scenarios followed by randomized traffic. The reference model is
// a queue of the words currently held; the expected block is assembled from
// that queue whenever it holds four words.
// ---------------------------------------------------------------------------
module tb_shift_register_32to128;

    logic         clk;
    logic         reset;
    logic         clear;
    logic [31:0]  data_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_out;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   word_cnt;

    int checkCount;
    int passCount;

    logic [31:0]  heldWords[$];
    logic [127:0] lastBlock;

    shift_register_32to128 dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one observed value against its expected value and counts it.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Builds the 128-bit block from four words in arrival order.
    function automatic logic [127:0] buildBlock(input logic [31:0] w0, input logic [31:0] w1,
                                                input logic [31:0] w2, input logic [31:0] w3);
`ifdef SR32TO128_LSB_FIRST_EN
        return {w3, w2, w1, w0};
`else
        return {w0, w1, w2, w3};
`endif
    endfunction

    // Expected word_cnt/out_valid (and block when full) after each edge.
    task automatic checkState(input string tag);
        checkOutput({tag, ".word_cnt"}, {125'b0, word_cnt}, 128'(heldWords.size()));
        checkOutput({tag, ".out_valid"}, {127'b0, out_valid}, {127'b0, heldWords.size() == 4});
        if (heldWords.size() == 4) begin
            checkOutput({tag, ".data_out"}, data_out,
                        buildBlock(heldWords[0], heldWords[1], heldWords[2], heldWords[3]));
        end
    endtask

    // Drives one cycle of inputs, checks in_ready before the edge, then advances the model.
    task automatic applyStimulus(input string tag, input logic iv, input logic [31:0] din,
                                 input logic ordy, input logic clr);
        bit full;
        bit inXfer;
        @(negedge clk);
        in_valid  = iv;
        data_in   = din;
        out_ready = ordy;
        clear     = clr;
        #1;
        full = (heldWords.size() == 4);
        checkOutput({tag, ".in_ready"}, {127'b0, in_ready}, {127'b0, (!full) || ordy});
        @(posedge clk);
        #1;
        inXfer = iv && ((!full) || ordy);
        if (clr) begin
            heldWords.delete();
        end else begin
            if (full && ordy) begin
                lastBlock = buildBlock(heldWords[0], heldWords[1], heldWords[2], heldWords[3]);
                heldWords.delete();
            end
            if (inXfer) begin
                heldWords.push_back(din);
            end
        end
        checkState(tag);
    endtask

    // Checks the values every reset or clear must leave behind.
    task automatic checkCleared(input string tag);
        checkOutput({tag, ".word_cnt"}, {125'b0, word_cnt}, 128'd0);
        checkOutput({tag, ".out_valid"}, {127'b0, out_valid}, 128'd0);
        checkOutput({tag, ".in_ready"}, {127'b0, in_ready}, 128'd1);
        checkOutput({tag, ".data_out"}, data_out, 128'h0);
    endtask

    initial begin
        logic [127:0] heldBlock;
        checkCount = 0;
        passCount  = 0;
        reset      = 1'b0;
        clear      = 1'b0;
        data_in    = 32'h0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        heldWords.delete();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkCleared("reset");
        @(negedge clk);
        reset = 1'b1;

        // Scenario 1: four words, consumer stalled
        applyStimulus("s1w0", 1'b1, 32'h00112233, 1'b0, 1'b0);
        applyStimulus("s1w1", 1'b1, 32'h44556677, 1'b0, 1'b0);
        applyStimulus("s1w2", 1'b1, 32'h8899AABB, 1'b0, 1'b0);
        applyStimulus("s1w3", 1'b1, 32'hCCDDEEFF, 1'b0, 1'b0);
`ifdef SR32TO128_LSB_FIRST_EN
        checkOutput("s1.block", data_out, 128'hCCDDEEFF_8899AABB_44556677_00112233);
`else
        checkOutput("s1.block", data_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);
`endif
        checkOutput("s1.in_ready", {127'b0, in_ready}, 128'd0);
        heldBlock = data_out;

        // Scenario 2: stalled consumer, source keeps offering a word
        for (int i = 0; i < 10; i++) begin
            applyStimulus("s2", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        end
        checkOutput("s2.block_held", data_out, heldBlock);

        // Scenario 3: consume and accept on the same edge
        applyStimulus("s3", 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
        checkOutput("s3.word_cnt", {125'b0, word_cnt}, 128'd1);
        checkOutput("s3.consumed", lastBlock, heldBlock);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("s3fill", 1'b1, $urandom, 1'b0, 1'b0);
        end
`ifdef SR32TO128_LSB_FIRST_EN
        checkOutput("s3.word0", {96'b0, data_out[31:0]}, 128'hA5A5A5A5);
`else
        checkOutput("s3.word0", {96'b0, data_out[127:96]}, 128'hA5A5A5A5);
`endif
        applyStimulus("s3drain", 1'b0, 32'h0, 1'b1, 1'b0);

        // Scenario 4: clear after two words wins over an offered word
        applyStimulus("s4w0", 1'b1, 32'h11111111, 1'b0, 1'b0);
        applyStimulus("s4w1", 1'b1, 32'h22222222, 1'b0, 1'b0);
        applyStimulus("s4clr", 1'b1, 32'h33333333, 1'b0, 1'b1);
        checkCleared("s4clr");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus("s4new", 1'b1, 32'(i), 1'b0, 1'b0);
        end
`ifdef SR32TO128_LSB_FIRST_EN
        checkOutput("s4.block", data_out, 128'h00000004_00000003_00000002_00000001);
`else
        checkOutput("s4.block", data_out, 128'h00000001_00000002_00000003_00000004);
`endif
        applyStimulus("s4drain", 1'b0, 32'h0, 1'b1, 1'b0);

        // Scenario 5: asynchronous reset between edges after three words
        for (int i = 0; i < 3; i++) begin
            applyStimulus("s5w", 1'b1, $urandom, 1'b0, 1'b0);
        end
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        checkCleared("s5async");
        heldWords.delete();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("s5n0", 1'b1, 32'hCAFE0000, 1'b0, 1'b0);
        applyStimulus("s5n1", 1'b1, 32'hCAFE0001, 1'b0, 1'b0);
        applyStimulus("s5n2", 1'b1, 32'hCAFE0002, 1'b0, 1'b0);
        applyStimulus("s5n3", 1'b1, 32'hCAFE0003, 1'b0, 1'b0);
`ifdef SR32TO128_LSB_FIRST_EN
        checkOutput("s5.block", data_out, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);
`else
        checkOutput("s5.block", data_out, 128'hCAFE0000_CAFE0001_CAFE0002_CAFE0003);
`endif

        // Randomized traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 3) != 0), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/shift_register_32to128.md
SHIFT_REGISTER_32TO128 -- requirements
Module: shift_register_32to128

Interface
REQ-001 SHALL have port clk, input, 1 bit: main clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port clear, input, 1 bit: synchronous abort; discards partial and held blocks.
REQ-004 SHALL have port data_in, input, 32 bits: incoming word.
REQ-005 SHALL have port in_valid, input, 1 bit: data_in is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-007 SHALL have port data_out, output, 128 bits: assembled block, registered.
REQ-008 SHALL have port out_valid, output, 1 bit: data_out holds a complete block.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes data_out this cycle.
REQ-010 SHALL have port word_cnt, output, 3 bits: words currently held, range 0..4.

Function
REQ-011 SHALL transfer an input word only on a rising edge where in_valid=1 and in_ready=1.
REQ-012 SHALL transfer an output block only on a rising edge where out_valid=1 and out_ready=1.
REQ-013 SHALL implement two states: FILL (word_cnt 0..3, out_valid=0) and FULL (word_cnt=4, out_valid=1).
REQ-014 In FILL, SHALL drive in_ready=1.
REQ-015 In FULL, SHALL drive in_ready=out_ready, combinationally.
REQ-016 SHALL place input word k (k=0..3, in acceptance order) in data_out[127-32k -: 32]: first word at MSB, matching the 128-to-32 serializer's MSB-first output order.
REQ-017 SHALL assert out_valid on the same edge that accepts the 4th word: zero bubble cycles.
REQ-018 On that edge, SHALL set word_cnt=4 and move FILL to FULL.
REQ-019 In FULL, SHALL hold data_out and out_valid stable until an output transfer occurs.
REQ-020 FULL with output transfer and no input transfer: SHALL go to FILL with word_cnt=0.
REQ-021 FULL with output and input transfer on the same edge: SHALL store the new word as word 0 of the next block, go to FILL, and set word_cnt=1.
REQ-022 SHALL leave data_out bits of not-yet-written words at their previous values while in FILL; consumers use data_out only when out_valid=1.
REQ-023 clear=1 SHALL take priority over all transfers: next state FILL, word_cnt=0, out_valid=0, and data_out=0.
REQ-024 in_valid=1 while in_ready=0 SHALL cause no state change; the source holds the word.
REQ-025 word_cnt SHALL never exceed 4 and SHALL never wrap.

Reset
REQ-026 reset=0 SHALL immediately force the following, regardless of clk: state FILL, word_cnt=0, out_valid=0, in_ready=1, data_out=128'h0.
REQ-027 SHALL discard any partially assembled block when reset is asserted mid-operation.
REQ-028 The first accepted word after reset deassertion SHALL be word 0.

Configuration
REQ-029 With macro SR32TO128_LSB_FIRST_EN defined, word k SHALL be placed in data_out[32k+31 -: 32], so the first word lands at the LSB end.
REQ-030 Without SR32TO128_LSB_FIRST_EN, word order SHALL be as in REQ-016.
REQ-031 The macro SHALL change only word placement; handshake, timing and reset behaviour are identical in both builds.

Verification
REQ-032 Scenario 1: after reset, send 00112233, 44556677, 8899AABB, CCDDEEFF on consecutive cycles with out_ready=0 -> out_valid=1 after the 4th edge; data_out=00112233_44556677_8899AABB_CCDDEEFF; word_cnt=4; in_ready=0.
REQ-033 Scenario 2: hold out_ready=0 for 10 cycles with in_valid=1 and data_in=DEADBEEF -> data_out unchanged; word_cnt=4; no word accepted.
REQ-034 Scenario 3: while FULL, set out_ready=1, in_valid=1, data_in=A5A5A5A5 on one edge -> block consumed; word_cnt=1; out_valid=0; next complete block has A5A5A5A5 in bits 127:96.
REQ-035 Scenario 4: after 2 words, pulse clear one cycle, then send 4 new words 1, 2, 3, 4 -> data_out=00000001_00000002_00000003_00000004; old words absent.
REQ-036 Scenario 5: assert reset=0 mid-cycle after 3 words -> outputs reset asynchronously to REQ-026 values; the next 4 words form a fresh block.
REQ-037 Scenario 6: build with SR32TO128_LSB_FIRST_EN and rerun Scenario 1 -> data_out=CCDDEEFF_8899AABB_44556677_00112233.
